adc_line_seq: RTL
=================

ADC_LINE_SEQ -- requirements
Module: adc_line_seq

Interface
REQ-001 Parameter PIXELS_PER_LINE, default 112, pixels requested per line (2..255).
REQ-002 Parameter SAMPLE_GAP, default 4, idle clk cycles between the end of one conversion and the next request (0..15).
REQ-003 Parameter TIMEOUT, default 64, max clk cycles spent in CONV before abort.
REQ-004 Parameter FIFO_DEPTH, default 16, output FIFO entries (power of 2).
REQ-005 clk  in  1  single clock; all logic on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 enable  in  1  sequencer enable; low aborts the line after the current conversion.
REQ-008 line_start  in  1  one-cycle pulse requesting a line capture.
REQ-009 clear_err  in  1  clears sticky overflow and timeout flags.
REQ-010 tp_sel  in  1  test-pattern select (see Configuration).
REQ-011 adc_start_n  out  1  conversion request to the ADC driver, active low.
REQ-012 adc_done_n  in  1  conversion-complete from the ADC driver, active low.
REQ-013 adc_data  in  8  converted sample from the ADC driver.
REQ-014 pix_data  out  8  FIFO head sample.
REQ-015 pix_last  out  1  FIFO head is the final pixel of a line.
REQ-016 pix_valid  out  1  FIFO non-empty.
REQ-017 pix_ready  in  1  consumer accepts head when pix_valid and pix_ready.
REQ-018 busy  out  1  high in any state except IDLE.
REQ-019 overflow  out  1  sticky: a sample was dropped on a full FIFO.
REQ-020 timeout  out  1  sticky: a conversion exceeded TIMEOUT.

Function
REQ-021 FSM states SHALL be IDLE, CONV, GAP; all outputs registered.
REQ-022 IDLE -> CONV when line_start=1 and enable=1; pixel counter cleared to 0; line_start while busy SHALL be ignored.
REQ-023 In CONV, adc_start_n SHALL be 0; elsewhere 1.
REQ-024 Capture event: adc_done_n registered previous value 1 and current value 0 while in CONV; adc_data sampled that cycle.
REQ-025 On capture: push {last, sample} to FIFO, last = (pixel counter == PIXELS_PER_LINE-1); adc_start_n returns to 1 the next cycle.
REQ-026 After capture: if last or enable=0 -> IDLE; else counter+1 and -> GAP.
REQ-027 GAP SHALL hold SAMPLE_GAP cycles, then -> CONV; SAMPLE_GAP=0 goes directly to CONV next cycle.
REQ-028 CONV cycle counter reaching TIMEOUT without capture SHALL set timeout and -> IDLE; no FIFO push.
REQ-029 Push on full FIFO SHALL drop the sample, set overflow, and otherwise proceed normally (counter still advances).
REQ-030 Simultaneous push and pop on a full FIFO SHALL count as full: sample dropped.
REQ-031 Simultaneous push and pop on a non-empty, non-full FIFO SHALL keep occupancy unchanged.
REQ-032 clear_err coincident with a new overflow/timeout event SHALL leave the flag set.
REQ-033 FIFO pointers wrap modulo FIFO_DEPTH; pix_valid asserted the cycle after the first push into an empty FIFO.

Reset
REQ-034 reset SHALL force IDLE, adc_start_n=1, busy=0, overflow=0, timeout=0, FIFO empty (pix_valid=0), pix_data=0, pix_last=0, all counters 0.
REQ-035 reset mid-line SHALL abandon the line immediately; no partial pix_last is emitted.

Configuration
REQ-036 Macro ADC_LINE_SEQ_TESTPAT_EN: when defined and tp_sel=1, the pushed sample SHALL be the pixel counter value instead of adc_data (ADC handshake unchanged).
REQ-037 Without ADC_LINE_SEQ_TESTPAT_EN, tp_sel SHALL be ignored and adc_data always pushed.

Structure
REQ-038 Shared package adc_seq_pkg SHALL hold ADC_RES=8, state encodings, and parameter defaults.
REQ-039 Output FIFO SHALL be a sub-module pix_fifo (sync, one clock, width ADC_RES+1).

Verification
REQ-040 Line of 4 pixels (PIXELS_PER_LINE=4), ADC model returning 0x10,0x20,0x30,0x40, pix_ready=1 -> four outputs in order, pix_last only on 0x40, busy low after.
REQ-041 FIFO_DEPTH=4, 6-pixel line, pix_ready=0 -> 4 entries held, overflow=1, counter completes line, clear_err drops overflow.
REQ-042 ADC model never lowers adc_done_n -> timeout=1 after 64 CONV cycles, adc_start_n=1, state IDLE, FIFO empty.
REQ-043 enable dropped during pixel 2 of 8 -> pixel 2 pushed, no further requests, pix_last never asserted.
REQ-044 reset asserted in GAP -> next cycle all outputs at REQ-034 values.
REQ-045 With ADC_LINE_SEQ_TESTPAT_EN, tp_sel=1, 3-pixel line -> outputs 0x00,0x01,0x02 regardless of adc_data.

Source files
------------

// File: rtl/adc_seq_pkg.sv
// Shared definitions for the ADC line sequencer: sample resolution, FSM state
// encoding, FIFO entry layout and parameter defaults.
package adc_seq_pkg;

    localparam int unsigned ADC_RES = 8;

    localparam int unsigned PIXELS_PER_LINE_DEF = 112;
    localparam int unsigned SAMPLE_GAP_DEF      = 4;
    localparam int unsigned TIMEOUT_DEF         = 64;
    localparam int unsigned FIFO_DEPTH_DEF      = 16;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StConv = 2'd1,
        StGap  = 2'd2
    } seqState_e;

    typedef struct packed {
        logic               last;
        logic [ADC_RES-1:0] sample;
    } pixEntry_t;

endpackage

// File: rtl/adc_line_seq_if.sv
// ADC handshake and pixel stream bundle. The sequencer uses the master side,
// the ADC driver / pixel consumer environment uses the slave side.
interface adc_line_seq_if;
    import adc_seq_pkg::*;

    logic               adc_start_n;
    logic               adc_done_n;
    logic [ADC_RES-1:0] adc_data;
    logic [ADC_RES-1:0] pix_data;
    logic               pix_last;
    logic               pix_valid;
    logic               pix_ready;

    modport master (
        output adc_start_n, pix_data, pix_last, pix_valid,
        input  adc_done_n, adc_data, pix_ready
    );

    modport slave (
        input  adc_start_n, pix_data, pix_last, pix_valid,
        output adc_done_n, adc_data, pix_ready
    );

endinterface

// File: rtl/pix_fifo.sv
// Synchronous single-clock FIFO with registered head/valid outputs.
// A push while full is ignored even if a pop happens in the same cycle.
module pix_fifo
    import adc_seq_pkg::*;
#(
    parameter int unsigned DEPTH = FIFO_DEPTH_DEF,
    parameter int unsigned WIDTH = ADC_RES + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic             full,
    output logic [WIDTH-1:0] head,
    output logic             valid
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] CountFull = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wrPtrQ, wrPtrD, rdPtrQ, rdPtrD;
    logic [AW:0]      countQ, countD;
    logic [WIDTH-1:0] headQ, headD;
    logic             validQ;
    logic             wrEn, rdEn;

    assign full  = (countQ == CountFull);
    assign wrEn  = push && !full;
    assign rdEn  = pop && validQ;
    assign head  = headQ;
    assign valid = validQ;

    // Pointer/occupancy update and the head value as it will look next cycle
    always_comb begin
        wrPtrD = wrEn ? wrPtrQ + AW'(1) : wrPtrQ;
        rdPtrD = rdEn ? rdPtrQ + AW'(1) : rdPtrQ;
        countD = countQ;
        if (wrEn && !rdEn) begin
            countD = countQ + (AW+1)'(1);
        end else if (!wrEn && rdEn) begin
            countD = countQ - (AW+1)'(1);
        end
        headD = '0;
        if (countD != '0) begin
            // The new head may be the entry being written this very cycle
            headD = (wrEn && (wrPtrQ == rdPtrD)) ? wdata : mem[rdPtrD];
        end
    end

    // Storage array, no reset needed since the head is masked when empty
    always_ff @(posedge clk) begin
        if (wrEn) begin
            mem[wrPtrQ] <= wdata;
        end
    end

    // Control registers
    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtrQ <= '0;
            rdPtrQ <= '0;
            countQ <= '0;
            headQ  <= '0;
            validQ <= 1'b0;
        end else begin
            wrPtrQ <= wrPtrD;
            rdPtrQ <= rdPtrD;
            countQ <= countD;
            headQ  <= headD;
            validQ <= (countD != '0);
        end
    end

endmodule

// File: rtl/adc_line_seq.sv
// ADC line sequencer: on line_start requests PIXELS_PER_LINE conversions from
// an ADC driver, spacing them by SAMPLE_GAP idle cycles, and queues the
// samples with an end-of-line marker into pix_fifo.
// Optional feature: define ADC_LINE_SEQ_TESTPAT_EN to let tp_sel replace the
// ADC sample by the pixel index.
module adc_line_seq
    import adc_seq_pkg::*;
#(
    parameter int unsigned PIXELS_PER_LINE = PIXELS_PER_LINE_DEF,
    parameter int unsigned SAMPLE_GAP      = SAMPLE_GAP_DEF,
    parameter int unsigned TIMEOUT         = TIMEOUT_DEF,
    parameter int unsigned FIFO_DEPTH      = FIFO_DEPTH_DEF
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           enable,
    input  logic           line_start,
    input  logic           clear_err,
    input  logic           tp_sel,
    adc_line_seq_if.master bus,
    output logic           busy,
    output logic           overflow,
    output logic           timeout
);
    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0]      ConvLast = CW'(TIMEOUT - 1);
    localparam logic [ADC_RES-1:0] PixLast  = ADC_RES'(PIXELS_PER_LINE - 1);
    localparam logic [3:0]         GapLast  = 4'(SAMPLE_GAP - 1);
    localparam bit                 GapZero  = (SAMPLE_GAP == 0);

    seqState_e          stateQ, stateD;
    logic [ADC_RES-1:0] pixCntQ, pixCntD;
    logic [CW-1:0]      convCntQ, convCntD;
    logic [3:0]         gapCntQ, gapCntD;
    logic               doneQ;
    logic               startNQ, busyQ, overflowQ, timeoutQ;
    logic               overflowD, timeoutD;
    logic               capture, push, timeoutEvt;
    logic [ADC_RES-1:0] sample;
    pixEntry_t          entry, headEntry;
    logic               fifoFull, fifoValid;

`ifdef ADC_LINE_SEQ_TESTPAT_EN
    assign sample = tp_sel ? pixCntQ : bus.adc_data;
`else
    logic unusedTpSel;
    assign unusedTpSel = tp_sel;
    assign sample = bus.adc_data;
`endif

    // Sequencing: conversion handshake, gap timing, timeout and line end
    always_comb begin
        stateD       = stateQ;
        pixCntD      = pixCntQ;
        convCntD     = convCntQ;
        gapCntD      = gapCntQ;
        push         = 1'b0;
        timeoutEvt   = 1'b0;
        capture      = (stateQ == StConv) && doneQ && !bus.adc_done_n;
        entry.last   = (pixCntQ == PixLast);
        entry.sample = sample;
        unique case (stateQ)
            StIdle: begin
                if (line_start && enable) begin
                    stateD   = StConv;
                    pixCntD  = '0;
                    convCntD = '0;
                end
            end
            StConv: begin
                if (capture) begin
                    push     = 1'b1;
                    convCntD = '0;
                    if (entry.last || !enable) begin
                        stateD = StIdle;
                    end else begin
                        pixCntD = pixCntQ + ADC_RES'(1);
                        gapCntD = '0;
                        stateD  = GapZero ? StConv : StGap;
                    end
                end else if (convCntQ == ConvLast) begin
                    timeoutEvt = 1'b1;
                    convCntD   = '0;
                    stateD     = StIdle;
                end else begin
                    convCntD = convCntQ + CW'(1);
                end
            end
            StGap: begin
                // Nothing is in flight here, so a dropped enable ends the line now
                if (!enable) begin
                    stateD = StIdle;
                end else if (gapCntQ == GapLast) begin
                    gapCntD = '0;
                    stateD  = StConv;
                end else begin
                    gapCntD = gapCntQ + 4'd1;
                end
            end
            default: stateD = StIdle;
        endcase
        // A new event wins over a coincident clear
        overflowD = (push && fifoFull) || (overflowQ && !clear_err);
        timeoutD  = timeoutEvt || (timeoutQ && !clear_err);
    end

    // State, counters and registered status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            stateQ    <= StIdle;
            pixCntQ   <= '0;
            convCntQ  <= '0;
            gapCntQ   <= '0;
            doneQ     <= 1'b1;
            startNQ   <= 1'b1;
            busyQ     <= 1'b0;
            overflowQ <= 1'b0;
            timeoutQ  <= 1'b0;
        end else begin
            stateQ    <= stateD;
            pixCntQ   <= pixCntD;
            convCntQ  <= convCntD;
            gapCntQ   <= gapCntD;
            doneQ     <= bus.adc_done_n;
            startNQ   <= (stateD != StConv);
            busyQ     <= (stateD != StIdle);
            overflowQ <= overflowD;
            timeoutQ  <= timeoutD;
        end
    end

    pix_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ADC_RES + 1)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .wdata (entry),
        .pop   (bus.pix_ready),
        .full  (fifoFull),
        .head  (headEntry),
        .valid (fifoValid)
    );

    assign bus.adc_start_n = startNQ;
    assign bus.pix_data    = headEntry.sample;
    assign bus.pix_last    = headEntry.last;
    assign bus.pix_valid   = fifoValid;
    assign busy            = busyQ;
    assign overflow        = overflowQ;
    assign timeout         = timeoutQ;

endmodule
